// File: rtl/vxe_cu_cmd_dec_pipe.sv
// VxE control-unit command decoder: handshaked decode, legality checks, output FIFO, error halt.
// Define VXE_CU_CMD_DEC_RSVD_CHK_EN to also flag words with non-zero reserved bits.
module vxe_cu_cmd_dec_pipe #(
    parameter int unsigned NR_THREADS = 8,
    parameter int unsigned OUT_DEPTH  = 2
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        i_cmd_vld,
    input  logic [63:0] i_cmd,
    output logic        o_cmd_rdy,
    output logic        o_dec_vld,
    input  logic        i_dec_rdy,
    output logic [4:0]  o_dec_op,
    output logic [7:0]  o_dec_fun,
    output logic [37:0] o_dec_pl,
    output logic        o_dec_err,
    output logic        o_halted,
    input  logic        i_err_clr,
    output logic [63:0] o_err_cmd,
    output logic [7:0]  o_err_cnt
);

    localparam int unsigned AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int unsigned EW = 5 + 8 + 38 + 1;
    localparam logic [AW:0] DepthCnt = (AW + 1)'(OUT_DEPTH);
    localparam logic [8:0]  NrThr    = 9'(NR_THREADS);

    localparam logic [4:0] OpNop    = 5'h00;
    localparam logic [4:0] OpProd   = 5'h01;
    localparam logic [4:0] OpRelu   = 5'h02;
    localparam logic [4:0] OpSetacc = 5'h08;
    localparam logic [4:0] OpSetvl  = 5'h09;
    localparam logic [4:0] OpSeten  = 5'h0A;
    localparam logic [4:0] OpSetrs  = 5'h0C;
    localparam logic [4:0] OpSetrt  = 5'h0D;
    localparam logic [4:0] OpSetrd  = 5'h0E;
    localparam logic [4:0] OpStore  = 5'h10;
    localparam logic [4:0] OpSync   = 5'h18;

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    state_e        state_q, state_d;
    logic [EW-1:0] mem_q [OUT_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic [63:0]   err_cmd_q, err_cmd_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    logic [4:0]    op;
    logic [7:0]    fun;
    logic [37:0]   pl;
    logic          op_legal, thr_chk, thr_bad, relu_bad, rsvd_bad, dec_err;
    logic          push, pop;
    logic [EW-1:0] head;

    assign op  = i_cmd[63:59];
    assign fun = i_cmd[58:51];
    assign pl  = i_cmd[37:0];

    always_comb begin
        op_legal = 1'b0;
        thr_chk  = 1'b0;
        relu_bad = 1'b0;
        case (op)
            OpNop, OpProd, OpStore, OpSync: op_legal = 1'b1;
            OpRelu: begin
                op_legal = 1'b1;
                relu_bad = (fun > 8'd1);
            end
            OpSetacc, OpSetvl, OpSeten, OpSetrs, OpSetrt, OpSetrd: begin
                op_legal = 1'b1;
                thr_chk  = 1'b1;
            end
            default: op_legal = 1'b0;
        endcase
    end

    assign thr_bad = thr_chk && ({1'b0, fun} >= NrThr);

`ifdef VXE_CU_CMD_DEC_RSVD_CHK_EN
    always_comb begin
        rsvd_bad = 1'b0;
        case (op)
            OpNop, OpProd, OpStore:    rsvd_bad = |i_cmd[58:0];
            OpSync:                    rsvd_bad = |i_cmd[58:2];
            OpRelu:                    rsvd_bad = |i_cmd[50:7];
            OpSetacc:                  rsvd_bad = |i_cmd[50:32];
            OpSetvl:                   rsvd_bad = |i_cmd[50:20];
            OpSeten:                   rsvd_bad = |i_cmd[50:1];
            OpSetrs, OpSetrt, OpSetrd: rsvd_bad = |i_cmd[50:38];
            default:                   rsvd_bad = 1'b0;
        endcase
    end
`else
    // Bits [50:38] are never part of a decoded field when reserved checking is off.
    logic unused_rsvd;
    assign unused_rsvd = ^i_cmd[50:38];
    assign rsvd_bad    = 1'b0;
`endif

    assign dec_err = !op_legal || thr_bad || relu_bad || rsvd_bad;

    // No full-FIFO bypass: a pop in the same cycle does not open intake.
    assign o_cmd_rdy = (state_q == StRun) && (cnt_q < DepthCnt);
    assign o_dec_vld = (cnt_q != '0);
    assign push      = i_cmd_vld && o_cmd_rdy;
    assign pop       = o_dec_vld && i_dec_rdy;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push && pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int unsigned i = 0; i < OUT_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {op, fun, pl, dec_err};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            cnt_q <= cnt_d;
        end
    end

    assign head = mem_q[rd_ptr_q];
    assign {o_dec_op, o_dec_fun, o_dec_pl, o_dec_err} = head;

    always_comb begin
        state_d   = state_q;
        err_cmd_d = err_cmd_q;
        err_cnt_d = err_cnt_q;
        if (push && dec_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
        unique case (state_q)
            StRun: begin
                if (push && dec_err) begin
                    state_d   = StHalt;
                    err_cmd_d = i_cmd;
                end
            end
            StHalt: begin
                if (i_err_clr) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= StRun;
            err_cmd_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            err_cmd_q <= err_cmd_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_halted  = (state_q == StHalt);
    assign o_err_cmd = err_cmd_q;
    assign o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_vxe_cu_cmd_dec_pipe.sv
// Randomized and directed bench for vxe_cu_cmd_dec_pipe against a queue-based reference model.
// Honours VXE_CU_CMD_DEC_RSVD_CHK_EN the same way the design does.
module tb_vxe_cu_cmd_dec_pipe;

    localparam int unsigned NrThreads = 8;
    localparam int unsigned OutDepth  = 2;
`ifdef VXE_CU_CMD_DEC_RSVD_CHK_EN
    localparam bit RsvdChk = 1'b1;
`else
    localparam bit RsvdChk = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nrst;
    logic        i_cmd_vld;
    logic [63:0] i_cmd;
    logic        o_cmd_rdy;
    logic        o_dec_vld;
    logic        i_dec_rdy;
    logic [4:0]  o_dec_op;
    logic [7:0]  o_dec_fun;
    logic [37:0] o_dec_pl;
    logic        o_dec_err;
    logic        o_halted;
    logic        i_err_clr;
    logic [63:0] o_err_cmd;
    logic [7:0]  o_err_cnt;

    vxe_cu_cmd_dec_pipe #(
        .NR_THREADS(NrThreads),
        .OUT_DEPTH (OutDepth)
    ) u_dut (
        .clk      (clk),
        .nrst     (nrst),
        .i_cmd_vld(i_cmd_vld),
        .i_cmd    (i_cmd),
        .o_cmd_rdy(o_cmd_rdy),
        .o_dec_vld(o_dec_vld),
        .i_dec_rdy(i_dec_rdy),
        .o_dec_op (o_dec_op),
        .o_dec_fun(o_dec_fun),
        .o_dec_pl (o_dec_pl),
        .o_dec_err(o_dec_err),
        .o_halted (o_halted),
        .i_err_clr(i_err_clr),
        .o_err_cmd(o_err_cmd),
        .o_err_cnt(o_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [7:0]  fun;
        logic [37:0] pl;
        logic        err;
    } ent_t;

    ent_t        m_q[$];
    bit          m_halted;
    logic [63:0] m_err_cmd;
    int          m_err_cnt;
    int          n_chk;
    int          n_fail;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference decode: legality from the opcode list, then per-opcode field and reserved rules.
    function automatic bit ref_err(input logic [63:0] c);
        int op  = int'(c[63:59]);
        int fun = int'(c[58:51]);
        bit bad = 1'b0;
        int lo  = 0;
        int hi  = -1;
        case (op)
            0, 1, 16:   begin lo = 0;  hi = 58; end
            24:         begin lo = 2;  hi = 58; end
            2:          begin bad = (fun > 1); lo = 7; hi = 50; end
            8:          begin bad = (fun >= NrThreads); lo = 32; hi = 50; end
            9:          begin bad = (fun >= NrThreads); lo = 20; hi = 50; end
            10:         begin bad = (fun >= NrThreads); lo = 1;  hi = 50; end
            12, 13, 14: begin bad = (fun >= NrThreads); lo = 38; hi = 50; end
            default:    bad = 1'b1;
        endcase
        if (RsvdChk) begin
            for (int b = lo; b <= hi; b++) begin
                if (c[b]) bad = 1'b1;
            end
        end
        return bad;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_halted  = 1'b0;
        m_err_cmd = '0;
        m_err_cnt = 0;
    endtask

    // One cycle: check outputs against the model, drive inputs, advance the model past the next edge.
    task automatic step(input bit vld, input logic [63:0] cmd, input bit drdy, input bit clr);
        bit   m_rdy;
        bit   m_vld;
        bit   push;
        bit   pop;
        ent_t e;
        @(negedge clk);
        m_rdy = !m_halted && (m_q.size() < OutDepth);
        m_vld = (m_q.size() > 0);
        check_val("cmd_rdy", 64'(o_cmd_rdy), 64'(m_rdy));
        check_val("dec_vld", 64'(o_dec_vld), 64'(m_vld));
        check_val("halted", 64'(o_halted), 64'(m_halted));
        check_val("err_cnt", 64'(o_err_cnt), 64'(m_err_cnt));
        check_val("err_cmd", o_err_cmd, m_err_cmd);
        if (m_vld) begin
            check_val("dec_op", 64'(o_dec_op), 64'(m_q[0].op));
            check_val("dec_fun", 64'(o_dec_fun), 64'(m_q[0].fun));
            check_val("dec_pl", 64'(o_dec_pl), 64'(m_q[0].pl));
            check_val("dec_err", 64'(o_dec_err), 64'(m_q[0].err));
        end
        i_cmd_vld = vld;
        i_cmd     = cmd;
        i_dec_rdy = drdy;
        i_err_clr = clr;
        push = vld && m_rdy;
        pop  = m_vld && drdy;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            e.op  = cmd[63:59];
            e.fun = cmd[58:51];
            e.pl  = cmd[37:0];
            e.err = ref_err(cmd);
            m_q.push_back(e);
            if (e.err) begin
                m_halted  = 1'b1;
                m_err_cmd = cmd;
                if (m_err_cnt < 255) m_err_cnt++;
            end
        end else if (m_halted && clr) begin
            m_halted = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 64'h0, 1'b1, 1'b0);
    endtask

    function automatic logic [63:0] rand_cmd();
        logic [63:0] c;
        logic [4:0]  ops [12];
        ops = '{5'h00, 5'h01, 5'h02, 5'h08, 5'h09, 5'h0A, 5'h0C, 5'h0D, 5'h0E, 5'h10, 5'h18,
                5'h1F};
        c = {$urandom, $urandom};
        c[63:59] = ops[$urandom_range(11)];
        c[58:51] = ($urandom_range(7) == 0) ? 8'($urandom) : 8'($urandom_range(10));
        // Mostly keep reserved bits clear so the reserved check does not dominate.
        if ($urandom_range(3) != 0) c[50:38] = '0;
        if ($urandom_range(3) != 0) c[37:0] = 38'($urandom_range(255));
        return c;
    endfunction

    localparam logic [63:0] CmdSetacc = {5'h08, 8'h01, 19'h0, 32'hFFFF_FFFF};
    localparam logic [63:0] CmdSetvl  = {5'h09, 8'h02, 31'h0, 20'h00100};
    localparam logic [63:0] CmdBadOp  = 64'hF800_0000_0000_0000;
    localparam logic [63:0] CmdSetrs  = {5'h0C, 8'h10, 51'h0};
    localparam logic [63:0] CmdRelu   = {5'h02, 8'h11, 51'h0};
    localparam logic [63:0] CmdNopR   = 64'h1;
    localparam logic [63:0] CmdSyncR  = 64'hC000_0000_0000_0007;

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        nrst      = 1'b0;
        i_cmd_vld = 1'b0;
        i_cmd     = '0;
        i_dec_rdy = 1'b0;
        i_err_clr = 1'b0;
        model_reset();

        #12;
        check_val("rst_rdy", 64'(o_cmd_rdy), 64'd1);
        check_val("rst_vld", 64'(o_dec_vld), 64'd0);
        check_val("rst_err", 64'(o_dec_err), 64'd0);
        check_val("rst_fields", {13'h0, o_dec_op, o_dec_fun, o_dec_pl}, 64'd0);
        check_val("rst_halted", 64'(o_halted), 64'd0);
        check_val("rst_err_cmd", o_err_cmd, 64'd0);
        check_val("rst_err_cnt", 64'(o_err_cnt), 64'd0);
        @(negedge clk);
        nrst = 1'b1;

        // Two back-to-back legal words, each visible one cycle after acceptance.
        step(1'b1, CmdSetacc, 1'b1, 1'b0);
        step(1'b1, CmdSetvl, 1'b1, 1'b0);
        check_val("acc_op", 64'(o_dec_op), 64'h08);
        check_val("acc_pl", 64'(o_dec_pl[31:0]), 64'hFFFF_FFFF);
        step(1'b0, 64'h0, 1'b1, 1'b0);
        check_val("vl_op", 64'(o_dec_op), 64'h09);
        check_val("vl_pl", 64'(o_dec_pl[19:0]), 64'h00100);
        check_val("vl_err", 64'(o_dec_err), 64'd0);
        idle(2);

        // Backpressure: full after two NOPs, no bypass on the first pop.
        step(1'b1, 64'h0, 1'b0, 1'b0);
        step(1'b1, 64'h0, 1'b0, 1'b0);
        step(1'b1, 64'h0, 1'b0, 1'b0);
        check_val("full_rdy", 64'(o_cmd_rdy), 64'd0);
        step(1'b1, 64'h0, 1'b1, 1'b0);
        check_val("pop_no_bypass", 64'(o_cmd_rdy), 64'd0);
        step(1'b1, 64'h0, 1'b1, 1'b0);
        check_val("third_accept", 64'(o_cmd_rdy), 64'd1);
        idle(3);

        // Illegal opcode halts intake until a clear pulse.
        step(1'b1, CmdBadOp, 1'b1, 1'b0);
        step(1'b1, 64'h0, 1'b1, 1'b0);
        check_val("bad_err", 64'(o_dec_err), 64'd1);
        check_val("bad_halted", 64'(o_halted), 64'd1);
        check_val("bad_err_cmd", o_err_cmd, 64'hF800_0000_0000_0000);
        check_val("bad_err_cnt", 64'(o_err_cnt), 64'd1);
        check_val("bad_rdy", 64'(o_cmd_rdy), 64'd0);
        step(1'b1, 64'h0, 1'b1, 1'b0);
        step(1'b0, 64'h0, 1'b1, 1'b1);
        check_val("clr_rdy_same", 64'(o_cmd_rdy), 64'd0);
        step(1'b0, 64'h0, 1'b1, 1'b0);
        check_val("clr_rdy_next", 64'(o_cmd_rdy), 64'd1);

        // Thread-Id and ReLU-type violations.
        step(1'b1, CmdSetrs, 1'b1, 1'b0);
        step(1'b0, 64'h0, 1'b1, 1'b1);
        check_val("setrs_err", 64'(o_dec_err), 64'd1);
        step(1'b1, CmdRelu, 1'b1, 1'b0);
        step(1'b0, 64'h0, 1'b1, 1'b1);
        check_val("relu_err", 64'(o_dec_err), 64'd1);
        check_val("two_more_cnt", 64'(o_err_cnt), 64'd3);
        idle(2);

        // Reserved-bit words: errors only when the reserved check is built in.
        step(1'b1, CmdNopR, 1'b1, 1'b0);
        step(1'b0, 64'h0, 1'b1, 1'b1);
        check_val("nop_rsvd", 64'(o_dec_err), 64'(RsvdChk));
        step(1'b1, CmdSyncR, 1'b1, 1'b0);
        step(1'b0, 64'h0, 1'b1, 1'b1);
        check_val("sync_rsvd", 64'(o_dec_err), 64'(RsvdChk));
        idle(2);

        // Reset while halted with a full FIFO.
        step(1'b1, 64'h0, 1'b0, 1'b0);
        step(1'b1, CmdBadOp, 1'b0, 1'b0);
        step(1'b0, 64'h0, 1'b0, 1'b0);
        check_val("pre_rst_halted", 64'(o_halted), 64'd1);
        nrst = 1'b0;
        model_reset();
        #2;
        check_val("mrst_vld", 64'(o_dec_vld), 64'd0);
        check_val("mrst_halted", 64'(o_halted), 64'd0);
        check_val("mrst_cnt", 64'(o_err_cnt), 64'd0);
        check_val("mrst_rdy", 64'(o_cmd_rdy), 64'd1);
        @(negedge clk);
        nrst = 1'b1;
        idle(2);

        // Error counter saturation.
        for (int i = 0; i < 260; i++) begin
            step(1'b1, CmdBadOp, 1'b1, 1'b0);
            step(1'b0, 64'h0, 1'b1, 1'b1);
        end
        idle(1);
        check_val("cnt_sat", 64'(o_err_cnt), 64'd255);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(3) != 0, rand_cmd(), $urandom_range(3) != 0,
                 $urandom_range(4) == 0);
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
